// File: rtl/hazard3_bus_arbiter_2port_pkg.sv
// Shared definitions for the two-port Hazard3 bus arbiter: owner encoding,
// AHB hsize constants and hprot bit positions.
package hazard3_bus_arbiter_2port_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_I    = 2'd1,
        OWNER_D    = 2'd2
    } owner_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int HPROT_DATA = 0;
    localparam int HPROT_PRIV = 1;

    // Fetches are only ever halfword (0) or word (1).
    function automatic logic [2:0] fetch_hsize(input logic size);
        return size ? HSIZE_WORD : HSIZE_HALF;
    endfunction

    function automatic logic [3:0] make_hprot(input logic is_data, input logic priv);
        logic [3:0] p;
        p = 4'b0000;
        p[HPROT_DATA] = is_data;
        p[HPROT_PRIV] = priv;
        return p;
    endfunction

endpackage

// File: rtl/hazard3_arb_starve_ctr.sv
// Saturating count of I-side arbitration losses; raises force_i once the
// limit is reached so the next unlocked selection goes to the fetch side.
module hazard3_arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_addr_vld,
    input  logic i_addr_rdy,
    input  logic d_addr_rdy,
    output logic force_i
);

    localparam logic [3:0] LIMIT_C = 4'(LIMIT);

    logic [3:0] cnt_r;

    // Loss counter: cleared by an I acceptance or by I withdrawing its request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 4'd0;
        end else if (!i_addr_vld || i_addr_rdy) begin
            cnt_r <= 4'd0;
        end else if (d_addr_rdy && (cnt_r != LIMIT_C)) begin
            cnt_r <= cnt_r + 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign force_i = (cnt_r == LIMIT_C);

endmodule

// File: rtl/hazard3_bus_arbiter_2port.sv
// Shares one pipelined AHB-style port between fetch (I) and load/store (D).
// Optional fetch starvation guard: define HAZARD3_ARB_STARVE_GUARD_EN.
module hazard3_bus_arbiter_2port
    import hazard3_bus_arbiter_2port_pkg::*;
#(
    parameter int W_ADDR       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_ADDR-1:0] i_addr,
    input  logic              i_size,
    input  logic              i_priv,
    input  logic              i_addr_vld,
    output logic              i_addr_rdy,
    output logic [31:0]       i_data,
    output logic              i_data_err,
    output logic              i_data_vld,
    input  logic [W_ADDR-1:0] d_addr,
    input  logic [1:0]        d_size,
    input  logic              d_write,
    input  logic              d_priv,
    input  logic [31:0]       d_wdata,
    input  logic              d_addr_vld,
    output logic              d_addr_rdy,
    output logic [31:0]       d_rdata,
    output logic              d_data_err,
    output logic              d_data_vld,
    output logic [W_ADDR-1:0] bus_addr,
    output logic [2:0]        bus_size,
    output logic              bus_write,
    output logic [3:0]        bus_prot,
    output logic              bus_addr_vld,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ready,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_err
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("hazard3_bus_arbiter_2port: STARVE_LIMIT must be 1..15");
    end

    logic   rst_done_r;
    logic   lock_r;
    owner_t lock_owner_r;
    owner_t dph_owner_r;
    owner_t sel_s;
    logic   force_i_s;
    logic   i_acc_s;
    logic   d_acc_s;

`ifdef HAZARD3_ARB_STARVE_GUARD_EN
    hazard3_arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_addr_vld (i_addr_vld),
        .i_addr_rdy (i_addr_rdy),
        .d_addr_rdy (d_addr_rdy),
        .force_i    (force_i_s)
    );
`else
    assign force_i_s = 1'b0;
`endif

    // Requester selection; a stalled address phase keeps its owner.
    always_comb begin
        sel_s = OWNER_NONE;
        if (lock_r) begin
            sel_s = lock_owner_r;
        end else if (force_i_s && i_addr_vld) begin
            sel_s = OWNER_I;
        end else if (d_addr_vld) begin
            sel_s = OWNER_D;
        end else if (i_addr_vld) begin
            sel_s = OWNER_I;
        end else begin
            sel_s = OWNER_NONE;
        end
    end

    // Address-phase mux; D fields are the idle default.
    always_comb begin
        bus_addr     = d_addr;
        bus_size     = {1'b0, d_size};
        bus_write    = d_write;
        bus_prot     = make_hprot(1'b1, d_priv);
        bus_addr_vld = 1'b0;
        case (sel_s)
            OWNER_I: begin
                bus_addr     = i_addr;
                bus_size     = fetch_hsize(i_size);
                bus_write    = 1'b0;
                bus_prot     = make_hprot(1'b0, i_priv);
                bus_addr_vld = rst_done_r && i_addr_vld;
            end
            OWNER_D: begin
                bus_addr_vld = rst_done_r && d_addr_vld;
            end
            default: begin
                bus_addr_vld = 1'b0;
            end
        endcase
    end

    assign i_addr_rdy = rst_done_r && bus_ready && (sel_s == OWNER_I);
    assign d_addr_rdy = rst_done_r && bus_ready && (sel_s == OWNER_D);
    assign i_acc_s    = i_addr_vld && i_addr_rdy;
    assign d_acc_s    = d_addr_vld && d_addr_rdy;

    // Reset-done flag, address-phase lock and data-phase ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_r   <= 1'b0;
            lock_r       <= 1'b0;
            lock_owner_r <= OWNER_NONE;
            dph_owner_r  <= OWNER_NONE;
        end else begin
            rst_done_r <= 1'b1;
            if (bus_ready) begin
                lock_r      <= 1'b0;
                dph_owner_r <= i_acc_s ? OWNER_I : (d_acc_s ? OWNER_D : OWNER_NONE);
            end else if (bus_addr_vld) begin
                lock_r       <= 1'b1;
                lock_owner_r <= sel_s;
            end else begin
                lock_r       <= lock_r;
                lock_owner_r <= lock_owner_r;
            end
        end
    end

    assign i_data_vld = bus_ready && (dph_owner_r == OWNER_I);
    assign d_data_vld = bus_ready && (dph_owner_r == OWNER_D);
    assign i_data_err = i_data_vld && bus_err;
    assign d_data_err = d_data_vld && bus_err;
    assign i_data     = bus_rdata;
    assign d_rdata    = bus_rdata;
    assign bus_wdata  = d_wdata;

endmodule

// File: tb/tb_hazard3_bus_arbiter_2port.sv
// Self-checking bench for hazard3_bus_arbiter_2port: directed steps from the
// test plan followed by randomized traffic against a behavioural model.
module tb_hazard3_bus_arbiter_2port;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_addr, d_addr, d_wdata, bus_rdata;
    logic        i_size, i_priv, i_addr_vld, d_write, d_priv, d_addr_vld;
    logic [1:0]  d_size;
    logic        bus_ready, bus_err;
    logic        i_addr_rdy, i_data_err, i_data_vld, d_addr_rdy, d_data_err, d_data_vld;
    logic [31:0] i_data, d_rdata, bus_addr, bus_wdata;
    logic [2:0]  bus_size;
    logic        bus_write, bus_addr_vld;
    logic [3:0]  bus_prot;

    hazard3_bus_arbiter_2port #(.W_ADDR(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_size(i_size), .i_priv(i_priv), .i_addr_vld(i_addr_vld),
        .i_addr_rdy(i_addr_rdy), .i_data(i_data), .i_data_err(i_data_err), .i_data_vld(i_data_vld),
        .d_addr(d_addr), .d_size(d_size), .d_write(d_write), .d_priv(d_priv), .d_wdata(d_wdata),
        .d_addr_vld(d_addr_vld), .d_addr_rdy(d_addr_rdy), .d_rdata(d_rdata),
        .d_data_err(d_data_err), .d_data_vld(d_data_vld),
        .bus_addr(bus_addr), .bus_size(bus_size), .bus_write(bus_write), .bus_prot(bus_prot),
        .bus_addr_vld(bus_addr_vld), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who owns a stalled address phase, who owns the data phase.
    bit m_rst_done;
    int m_stalled;   // 0 none, 1 I, 2 D
    int m_dph;       // 0 none, 1 I, 2 D
    int m_losses;
    int e_sel;
    bit e_bav, e_irdy, e_drdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_i(input bit vld, input logic [31:0] a, input bit sz, input bit pv);
        i_addr_vld = vld; i_addr = a; i_size = sz; i_priv = pv;
    endtask

    task automatic set_d(input bit vld, input logic [31:0] a, input logic [1:0] sz,
                         input bit wr, input bit pv, input logic [31:0] wd);
        d_addr_vld = vld; d_addr = a; d_size = sz; d_write = wr; d_priv = pv; d_wdata = wd;
    endtask

    // Evaluate expectations mid-cycle and compare every handshake output.
    task automatic sample();
        bit force_i;
        #4;
`ifdef HAZARD3_ARB_STARVE_GUARD_EN
        force_i = (m_losses >= LIMIT);
`else
        force_i = 1'b0;
`endif
        if (m_stalled != 0)            e_sel = m_stalled;
        else if (force_i && i_addr_vld) e_sel = 1;
        else if (d_addr_vld)           e_sel = 2;
        else if (i_addr_vld)           e_sel = 1;
        else                           e_sel = 0;
        e_bav  = m_rst_done && ((e_sel == 1 && i_addr_vld) || (e_sel == 2 && d_addr_vld));
        e_irdy = m_rst_done && bus_ready && e_sel == 1;
        e_drdy = m_rst_done && bus_ready && e_sel == 2;
        chk("bus_addr_vld", bus_addr_vld, e_bav);
        chk("i_addr_rdy", i_addr_rdy, e_irdy);
        chk("d_addr_rdy", d_addr_rdy, e_drdy);
        chk("i_data_vld", i_data_vld, bus_ready && m_dph == 1);
        chk("d_data_vld", d_data_vld, bus_ready && m_dph == 2);
        chk("i_data_err", i_data_err, bus_ready && bus_err && m_dph == 1);
        chk("d_data_err", d_data_err, bus_ready && bus_err && m_dph == 2);
        if (e_bav && e_sel == 1) begin
            chk("bus_addr_i", bus_addr, i_addr);
            chk("bus_size_i", bus_size, i_size ? 3'b010 : 3'b001);
            chk("bus_write_i", bus_write, 1'b0);
            chk("bus_prot_i", bus_prot, {2'b00, i_priv, 1'b0});
        end
        if (e_bav && e_sel == 2) begin
            chk("bus_addr_d", bus_addr, d_addr);
            chk("bus_size_d", bus_size, {1'b0, d_size});
            chk("bus_write_d", bus_write, d_write);
            chk("bus_prot_d", bus_prot, {2'b00, d_priv, 1'b1});
        end
        if (bus_ready && m_dph == 1) chk("i_data", i_data, bus_rdata);
        if (bus_ready && m_dph == 2) chk("d_rdata", d_rdata, bus_rdata);
        if (m_dph == 2) chk("bus_wdata", bus_wdata, d_wdata);
    endtask

    task automatic tick();
        bit i_acc;
        @(posedge clk);
        i_acc = e_irdy && i_addr_vld;
        if (bus_ready) begin
            m_dph     = i_acc ? 1 : ((e_drdy && d_addr_vld) ? 2 : 0);
            m_stalled = 0;
        end else if (e_bav) begin
            m_stalled = e_sel;
        end
        if (!i_addr_vld || i_acc)              m_losses = 0;
        else if (e_drdy && m_losses < LIMIT)   m_losses++;
        m_rst_done = 1'b1;
        #1;
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        m_rst_done = 1'b0; m_stalled = 0; m_dph = 0; m_losses = 0;
        #1;
        chk("rst_i_addr_rdy", i_addr_rdy, 1'b0);
        chk("rst_d_addr_rdy", d_addr_rdy, 1'b0);
        chk("rst_bus_addr_vld", bus_addr_vld, 1'b0);
        chk("rst_d_data_vld", d_data_vld, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        set_i(1'b1, 32'h40, 1'b1, 1'b0);
        set_d(1'b0, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0);
        bus_ready = 1'b1; bus_err = 1'b0; bus_rdata = 32'h0;
        apply_reset();

        // Fetch straight out of reset: no grant in the first cycle.
        sample(); chk("boot_no_rdy", i_addr_rdy, 1'b0); tick();
        sample(); chk("boot_i_rdy", i_addr_rdy, 1'b1); chk("boot_prot0", bus_prot[0], 1'b0); tick();
        set_i(1'b0, 32'h0, 1'b1, 1'b0); bus_rdata = 32'h1234_5678;
        sample(); chk("boot_i_dvld", i_data_vld, 1'b1); chk("boot_i_data", i_data, 32'h1234_5678); tick();

        // Both sides requesting every cycle.
        set_i(1'b1, 32'h80, 1'b1, 1'b1);
        set_d(1'b1, 32'h1000, 2'd2, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            bit exp_i;
`ifdef HAZARD3_ARB_STARVE_GUARD_EN
            exp_i = (k == LIMIT) || (k == 2 * LIMIT + 1);
`else
            exp_i = 1'b0;
`endif
            sample();
            chk("starve_i_grant", i_addr_rdy, exp_i);
            chk("starve_d_grant", d_addr_rdy, !exp_i);
            tick();
        end
        set_i(1'b0, 32'h0, 1'b0, 1'b0); set_d(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        step();

        // Stalled fetch address phase keeps the bus against a later D request.
        set_i(1'b1, 32'h100, 1'b1, 1'b0); bus_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) set_d(1'b1, 32'h3000, 2'd2, 1'b0, 1'b0, 32'h0);
            sample();
            chk("lock_addr", bus_addr, 32'h100);
            chk("lock_d_rdy", d_addr_rdy, 1'b0);
            tick();
        end
        bus_ready = 1'b1;
        sample(); chk("lock_i_acc", i_addr_rdy, 1'b1); chk("lock_d_wait", d_addr_rdy, 1'b0); tick();
        set_i(1'b0, 32'h0, 1'b0, 1'b0);
        sample(); chk("lock_d_next", d_addr_rdy, 1'b1); tick();
        set_d(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        step();

        // Store: size/write on the address phase, wdata in the data phase.
        set_d(1'b1, 32'h2000, 2'd2, 1'b1, 1'b0, 32'hDEAD_BEEF);
        sample(); chk("st_size", bus_size, 3'b010); chk("st_write", bus_write, 1'b1); tick();
        d_addr_vld = 1'b0;
        sample(); chk("st_wdata", bus_wdata, 32'hDEAD_BEEF);
        chk("st_d_dvld", d_data_vld, 1'b1); chk("st_i_dvld", i_data_vld, 1'b0); tick();

        // Fetch error response with a D address accepted alongside it.
        set_i(1'b1, 32'h200, 1'b1, 1'b0); set_d(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
        step();
        set_i(1'b0, 32'h0, 1'b0, 1'b0); set_d(1'b1, 32'h2004, 2'd2, 1'b0, 1'b1, 32'h0);
        bus_err = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        sample(); chk("err_i_err", i_data_err, 1'b1); chk("err_i_vld", i_data_vld, 1'b1);
        chk("err_d_err", d_data_err, 1'b0); chk("err_d_acc", d_addr_rdy, 1'b1); tick();
        bus_err = 1'b0; d_addr_vld = 1'b0; bus_rdata = 32'h0000_5A5A;
        sample(); chk("err_d_done", d_data_vld, 1'b1); chk("err_d_ok", d_data_err, 1'b0); tick();

        // Reset while a D data phase is outstanding.
        set_d(1'b1, 32'h2008, 2'd2, 1'b0, 1'b0, 32'h0);
        step();
        d_addr_vld = 1'b0; bus_ready = 1'b0;
        apply_reset();
        bus_ready = 1'b1;
        sample(); chk("rstmid_no_dvld0", d_data_vld, 1'b0); tick();
        sample(); chk("rstmid_no_dvld1", d_data_vld, 1'b0); tick();

        // Randomized traffic; a stalled requester holds its request.
        for (int n = 0; n < 400; n++) begin
            if (m_stalled != 1)
                set_i($urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            if (m_stalled != 2)
                set_d($urandom_range(0, 2) != 0, $urandom, 2'($urandom_range(0, 2)),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
            bus_ready = ($urandom_range(0, 3) != 0);
            bus_err   = ($urandom_range(0, 9) == 0);
            bus_rdata = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
